// File: rtl/conv_pkg.sv
// Shared types and constants for the KxK streaming convolution engine.
// Holds the default Sobel-y kernel, output mode encodings and a clog2 helper.
package conv_pkg;

  localparam int COEF_W_DEF = 4;

  typedef logic signed [COEF_W_DEF-1:0] coef_t;

  // Row-major Sobel-y kernel loaded into both banks at reset when K == 3
  localparam coef_t SOBEL_Y [9] = '{
    4'sd1,  4'sd2,  4'sd1,
    4'sd0,  4'sd0,  4'sd0,
    -4'sd1, -4'sd2, -4'sd1
  };

  localparam logic MODE_RAW = 1'b0;
  localparam logic MODE_ABS = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Enable-gated DEPTH x WIDTH shift register carrying row partial sums into the next kernel row.
// DEPTH == 0 degenerates to a wire (image exactly as wide as the kernel).
module conv_line_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sr <= '{default: '0};
      end else if (en) begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming KxK 2-D convolution in transposed systolic form with valid/ready flow control.
// Coefficients are written into a shadow bank and committed when pixel (0,0) of a frame is accepted.
module conv_kxk_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 4,
  parameter int ACC_W  = 16,
  parameter int K      = 3,
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         pxl_in,
  input  logic                      pxl_in_valid,
  output logic                      pxl_in_ready,
  input  logic                      coef_we,
  input  logic [clog2(K*K)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  input  logic                      mode,
  output logic signed [ACC_W-1:0]   pxl_out,
  output logic                      pxl_out_valid,
  input  logic                      pxl_out_ready,
  output logic                      pxl_out_last
);

  localparam int NCOEF    = K * K;
  localparam int AW       = clog2(NCOEF);
  localparam int CW       = clog2(IMG_W);
  localparam int RW       = clog2(IMG_H);
  localparam int LB_DEPTH = IMG_W - K;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [COEF_W-1:0] cw_t;

  localparam acc_t ACC_MIN = acc_t'({1'b1, {(ACC_W-1){1'b0}}});
  localparam acc_t ACC_MAX = acc_t'({1'b0, {(ACC_W-1){1'b1}}});
  localparam acc_t PIX_MAX = acc_t'({DATA_W{1'b1}});

  function automatic cw_t default_coef(input int idx);
    if (K == 3 && idx < 9) return cw_t'(SOBEL_Y[idx]);
    return '0;
  endfunction

  logic          accept;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          first_px;
  logic          last_px;
  logic          win_valid;

  cw_t  shadow   [NCOEF];
  cw_t  active   [NCOEF];
  cw_t  coef_use [NCOEF];
  acc_t mac      [K][K];
  acc_t mac_nxt  [K][K];
  acc_t lb_out   [K-1];
  acc_t px_ext;
  acc_t final_sum;
  acc_t mag;
  acc_t out_val;

  assign pxl_in_ready = !pxl_out_valid || pxl_out_ready;
  assign accept       = pxl_in_valid && pxl_in_ready;

  assign first_px  = (col == '0) && (row == '0);
  assign last_px   = (col == CW'(IMG_W-1)) && (row == RW'(IMG_H-1));
  assign win_valid = (col >= CW'(K-1)) && (row >= RW'(K-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(IMG_W-1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H-1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // The frame's first pixel already sees the committed bank, so the whole frame uses one coefficient set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCOEF; i++) begin
        shadow[i] <= default_coef(i);
        active[i] <= default_coef(i);
      end
    end else begin
      if (coef_we && ({1'b0, coef_addr} < (AW+1)'(NCOEF))) shadow[coef_addr] <= coef_data;
      if (accept && first_px) active <= shadow;
    end
  end

  always_comb begin
    for (int i = 0; i < NCOEF; i++) coef_use[i] = first_px ? shadow[i] : active[i];
  end

  assign px_ext = acc_t'(pxl_in);

  // Each cell adds its product to the left neighbour's register; column 0 takes the row above via a line buffer
  for (genvar kr = 0; kr < K; kr++) begin : g_row
    for (genvar kc = 0; kc < K; kc++) begin : g_cell
      acc_t pred;
      if (kc == 0 && kr == 0) begin : g_top
        assign pred = '0;
      end else if (kc == 0) begin : g_lb
        assign pred = lb_out[kr-1];
      end else begin : g_chain
        assign pred = mac[kr][kc-1];
      end
      assign mac_nxt[kr][kc] = pred + px_ext * acc_t'(coef_use[kr*K+kc]);
    end
  end

  for (genvar g = 0; g < K-1; g++) begin : g_lbuf
    conv_line_buf #(
      .DEPTH(LB_DEPTH),
      .WIDTH(ACC_W)
    ) u_line_buf (
      .clk  (clk),
      .reset(reset),
      .en   (accept),
      .din  (mac[g][K-1]),
      .dout (lb_out[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac <= '{default: '{default: '0}};
    end else if (accept) begin
      mac <= mac_nxt;
    end
  end

  assign final_sum = mac_nxt[K-1][K-1];

  always_comb begin
    if (final_sum == ACC_MIN) mag = ACC_MAX;
    else if (final_sum[ACC_W-1]) mag = -final_sum;
    else mag = final_sum;
    if (mode == MODE_ABS) out_val = (mag > PIX_MAX) ? PIX_MAX : mag;
    else out_val = final_sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_out       <= '0;
      pxl_out_valid <= 1'b0;
      pxl_out_last  <= 1'b0;
    end else if (accept) begin
      pxl_out       <= out_val;
      pxl_out_valid <= win_valid;
      pxl_out_last  <= last_px;
    end else if (pxl_out_ready) begin
      pxl_out_valid <= 1'b0;
      pxl_out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Bench for conv_kxk_stream: frame-level convolution model feeding a queue, checked by one monitor,
// plus literal expectations for ramp, backpressure, coefficient update, clipping and mid-frame reset.
module tb_conv_kxk_stream;

  localparam int K = 3, IMG_W = 5, IMG_H = 5, NPIX = IMG_W * IMG_H;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [7:0]         pxl_in = '0;
  logic               pxl_in_valid = 1'b0;
  logic               pxl_in_ready;
  logic               coef_we = 1'b0;
  logic [3:0]         coef_addr = '0;
  logic signed [3:0]  coef_data = '0;
  logic               mode = 1'b0;
  logic signed [15:0] pxl_out;
  logic               pxl_out_valid;
  logic               pxl_out_ready = 1'b1;
  logic               pxl_out_last;

  always #5 clk = ~clk;

  conv_kxk_stream #(
    .DATA_W(8), .COEF_W(4), .ACC_W(16), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pxl_in       (pxl_in),
    .pxl_in_valid (pxl_in_valid),
    .pxl_in_ready (pxl_in_ready),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .mode         (mode),
    .pxl_out      (pxl_out),
    .pxl_out_valid(pxl_out_valid),
    .pxl_out_ready(pxl_out_ready),
    .pxl_out_last (pxl_out_last)
  );

  typedef struct {
    int v;
    bit last;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t obs[$];
  int   model_shadow [9];
  int   model_active [9];
  int   img [IMG_H][IMG_W];
  int   checks = 0;
  int   failures = 0;
  int   accepts_total = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int obs_v(input int i);
    return (obs.size() > i) ? obs[i].v : -99999;
  endfunction

  function automatic int obs_last(input int i);
    return (obs.size() > i) ? int'(obs[i].last) : -1;
  endfunction

  function automatic int apply_mode(input int sum, input logic md);
    logic signed [15:0] s16;
    int v;
    s16 = 16'(sum);
    v = int'(s16);
    if (md) begin
      if (v == -32768) v = 32767;
      else if (v < 0) v = -v;
      if (v > 255) v = 255;
    end
    return v;
  endfunction

  task automatic load_sobel();
    model_shadow = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
  endtask

  // Direct convolution over every full window of the frame, in output order
  task automatic model_frame(input logic md);
    int n, sum;
    n = 0;
    model_active = model_shadow;
    for (int r = K-1; r < IMG_H; r++) begin
      for (int c = K-1; c < IMG_W; c++) begin
        sum = 0;
        for (int kr = 0; kr < K; kr++)
          for (int kc = 0; kc < K; kc++)
            sum += img[r-K+1+kr][c-K+1+kc] * model_active[kr*K+kc];
        exp_q.push_back('{v: apply_mode(sum, md), last: (r == IMG_H-1 && c == IMG_W-1), idx: n});
        n++;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!reset) begin
      accepts_total = 0;
    end else begin
      if (pxl_out_valid && pxl_out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("spurious_output", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_output("out_value", int'(pxl_out), e.v);
          check_output("out_last", int'(pxl_out_last), int'(e.last));
          if (e.idx == 0) check_output("first_out_accepts", accepts_total % NPIX, 13);
          obs.push_back('{v: int'(pxl_out), last: pxl_out_last, idx: e.idx});
        end
      end
      if (pxl_in_valid && pxl_in_ready) accepts_total++;
    end
  end

  task automatic drive_px(input logic [7:0] p, input logic md);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    pxl_in = p;
    pxl_in_valid = 1'b1;
    mode = md;
    pxl_out_ready = 1'b1;
    while (!done) begin
      #1;
      if (pxl_in_ready) done = 1'b1;
      @(negedge clk); #1;
      waited++;
      if (!done && waited > 50) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout: got %0d wait cycles expected below 50", waited);
        done = 1'b1;
      end
    end
    pxl_in_valid = 1'b0;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic signed [3:0] d);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    if (a < 9) model_shadow[a] = int'(d);
    @(negedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic apply_stimulus(input int kind, input logic md, input bit toggle, input bit stall,
                                input int wr_at, input logic [3:0] wr_addr,
                                input logic signed [3:0] wr_data, input int stop_at);
    bit stalled;
    stalled = 1'b0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = (kind == 0) ? 5*r + c : 200;
    model_frame(md);
    obs.delete();
    for (int i = 0; i < NPIX; i++) begin
      if (i == stop_at) return;
      if (toggle && (i % 2 == 1)) begin
        pxl_in_valid = 1'b0;
        @(negedge clk); #1;
      end
      // Hold the consumer off while the first result sits in the output register
      if (stall && !stalled && pxl_out_valid) begin
        stalled = 1'b1;
        pxl_in = 8'(img[i/IMG_W][i%IMG_W]);
        pxl_in_valid = 1'b1;
        pxl_out_ready = 1'b0;
        repeat (3) begin
          #1;
          check_output("stall_in_ready", int'(pxl_in_ready), 0);
          check_output("stall_out_hold", int'(pxl_out), -40);
          @(negedge clk); #1;
        end
      end
      if (i == wr_at) begin
        coef_we = 1'b1;
        coef_addr = wr_addr;
        coef_data = wr_data;
        if (wr_addr < 9) model_shadow[wr_addr] = int'(wr_data);
      end
      drive_px(8'(img[i/IMG_W][i%IMG_W]), md);
      coef_we = 1'b0;
    end
    pxl_in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
    end
    check_output("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_state();
    check_output("rst_pxl_out", int'(pxl_out), 0);
    check_output("rst_out_valid", int'(pxl_out_valid), 0);
    check_output("rst_out_last", int'(pxl_out_last), 0);
    check_output("rst_in_ready", int'(pxl_in_ready), 1);
  endtask

  initial begin
    load_sobel();
    repeat (3) @(negedge clk);
    #1;
    check_reset_state();
    reset = 1'b1;
    @(negedge clk); #1;

    $display("[TB] ramp, default kernel, raw mode");
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, -1, 4'd0, 4'sd0, -1);
    check_output("t1_count", obs.size(), 9);
    check_output("t1_first", obs_v(0), -40);
    check_output("t1_first_last", obs_last(0), 0);
    check_output("t1_ninth_last", obs_last(8), 1);

    $display("[TB] ramp, abs mode, steady and toggled valid");
    apply_stimulus(0, 1'b1, 1'b0, 1'b0, -1, 4'd0, 4'sd0, -1);
    check_output("t2_first", obs_v(0), 40);
    apply_stimulus(0, 1'b1, 1'b1, 1'b0, -1, 4'd0, 4'sd0, -1);
    check_output("t2_toggle_count", obs.size(), 9);
    check_output("t2_toggle_mid", obs_v(4), 40);

    $display("[TB] backpressure at first output");
    apply_stimulus(0, 1'b0, 1'b0, 1'b1, -1, 4'd0, 4'sd0, -1);
    check_output("t3_count", obs.size(), 9);
    check_output("t3_last_val", obs_v(8), -40);

    $display("[TB] mid-frame coefficient write");
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 7, 4'd4, 4'sd1, -1);
    check_output("t4_f1_first", obs_v(0), -40);
    check_output("t4_f1_last", obs_v(8), -40);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, -1, 4'd0, 4'sd0, -1);
    check_output("t4_f2_first", obs_v(0), -34);
    check_output("t4_f2_last", obs_v(8), -22);

    $display("[TB] constant image, all coefficients 7");
    for (int a = 0; a < 9; a++) write_coef(4'(a), 4'sd7);
    write_coef(4'd9, -4'sd8);
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, -1, 4'd0, 4'sd0, -1);
    check_output("t5_raw", obs_v(0), 12600);
    apply_stimulus(1, 1'b1, 1'b0, 1'b0, -1, 4'd0, 4'sd0, -1);
    check_output("t5_abs", obs_v(8), 255);

    $display("[TB] reset in the middle of a frame");
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, -1, 4'd0, 4'sd0, 11);
    pxl_in = 8'(img[2][1]);
    pxl_in_valid = 1'b1;
    reset = 1'b0;
    exp_q.delete();
    load_sobel();
    @(negedge clk); #1;
    check_reset_state();
    pxl_in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, -1, 4'd0, 4'sd0, -1);
    check_output("t6_count", obs.size(), 9);
    check_output("t6_first", obs_v(0), -40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got simulation time limit expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
